// File: rtl/exp_arb_pkg.sv
// Shared state encoding and Q24.40 constants for the exp core request arbiter.
package exp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RETURN   = 2'd3
    } arb_state_t;

    localparam int          Q_FRAC     = 40;
    localparam logic [63:0] Q_ONE      = 64'h0000_0100_0000_0000;
    localparam int          DW_DEFAULT = 64;

endpackage

// File: rtl/exp_request_arbiter_rr_arbiter.sv
// Rotating-priority request picker: searches upward from i_rr_ptr, wrapping at N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req_valid,
    input  logic [IDW-1:0]   i_rr_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDW-1:0]   o_grant_id,
    output logic             o_any
);

    always_comb begin
        int   w_idx;
        logic w_found;
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(i_rr_ptr) + k) % N_REQ;
            if (!w_found && i_req_valid[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = IDW'(w_idx);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/exp_request_arbiter.sv
// Shares one non-pipelined exp core between N_REQ requesters, one transaction at a time.
// Optional watchdog in WAIT_RSP is enabled by defining EXP_ARB_TIMEOUT_EN.
module exp_request_arbiter
    import exp_arb_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int DW             = DW_DEFAULT,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDW            = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ*DW-1:0] req_x,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       rsp_y,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic                rsp_err,
    output logic [DW-1:0]       core_x,
    output logic                core_x_valid,
    input  logic                core_x_ready,
    input  logic [DW-1:0]       core_y,
    input  logic                core_y_valid,
    output logic                core_y_ready,
    output logic                busy,
    output logic [IDW-1:0]      grant_id
);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("exp_request_arbiter: unsupported N_REQ or TIMEOUT_CYCLES");
    end

    arb_state_t       r_state;
    arb_state_t       w_next;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [DW-1:0]    r_x;
    logic [DW-1:0]    r_y;

    logic [N_REQ-1:0] w_grant;
    logic [IDW-1:0]   w_grant_id;
    logic             w_any;
    logic             w_stale;
    logic             w_tmo_hit;
    logic             w_accept;
    logic             w_capture;
    logic             w_timeout;
    logic             w_done;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_arbiter (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_any       (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Transaction strobes come from here so the datapath and watchdog see one decision.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !w_stale) begin
                    w_accept = 1'b1;
                    w_next   = ISSUE;
                end
            end
            ISSUE: begin
                if (core_x_ready) begin
                    w_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (core_y_valid) begin
                    w_capture = 1'b1;
                    w_next    = RETURN;
                end else if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                    w_next    = RETURN;
                end
            end
            RETURN: begin
                if (rsp_ready[r_id]) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            if (w_accept) begin
                r_x  <= req_x[int'(w_grant_id)*DW +: DW];
                r_id <= w_grant_id;
            end
            if (w_capture) begin
                r_y <= core_y;
            end else if (w_timeout) begin
                r_y <= '0;
            end
            if (w_done) begin
                r_rr_ptr <= (r_id == IDW'(N_REQ - 1)) ? '0 : r_id + 1'b1;
            end
        end
    end

`ifdef EXP_ARB_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_stale;
    logic        r_err;

    // A timed-out core still owes one result; it is swallowed in IDLE before new grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_stale   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == WAIT_RSP) ? r_tmo_cnt + 16'd1 : 16'd0;
            if (w_timeout) begin
                r_stale <= 1'b1;
            end else if (r_state == IDLE && r_stale && core_y_valid) begin
                r_stale <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (w_capture) begin
                r_err <= 1'b0;
            end
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign w_stale   = r_stale;
    assign rsp_err   = r_err;
`else
    assign w_tmo_hit = 1'b0;
    assign w_stale   = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign req_ready    = w_accept ? w_grant : '0;
    assign rsp_valid    = (r_state == RETURN) ? (N_REQ'(1) << r_id) : '0;
    assign rsp_y        = r_y;
    assign core_x       = r_x;
    assign core_x_valid = (r_state == ISSUE);
    assign core_y_ready = (r_state == WAIT_RSP) || (r_state == IDLE && w_stale);
    assign busy         = (r_state != IDLE);
    assign grant_id     = r_id;

endmodule
